// File: rtl/ram_dp_if.sv
// ============================================================================
//  Module   : ram_dp_if
//  Brief    : Write/read bus between the RAM environment and ram_dp_responder.
//             Parity signals exist only when RAM_PARITY_EN is defined.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface ram_dp_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_din;
  logic                  re;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_dout;
  logic                  rd_valid;
  logic                  rd_unwritten;
`ifdef RAM_PARITY_EN
  logic                  wr_par_flip;
  logic                  rd_parity_err;

  modport master (
    output we, wr_addr, wr_din, re, rd_addr, wr_par_flip,
    input  rd_dout, rd_valid, rd_unwritten, rd_parity_err
  );
  modport slave (
    input  we, wr_addr, wr_din, re, rd_addr, wr_par_flip,
    output rd_dout, rd_valid, rd_unwritten, rd_parity_err
  );
`else
  modport master (
    output we, wr_addr, wr_din, re, rd_addr,
    input  rd_dout, rd_valid, rd_unwritten
  );
  modport slave (
    input  we, wr_addr, wr_din, re, rd_addr,
    output rd_dout, rd_valid, rd_unwritten
  );
`endif
endinterface

`default_nettype wire

// File: rtl/ram_dp_responder.sv
// ============================================================================
//  Module   : ram_dp_responder
//  Brief    : Simple dual-port synchronous RAM with pipelined, write-first read
//             path and per-word written flags. Optional macro RAM_PARITY_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ram_dp_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  wire logic clk,
  input  wire logic rst_n,
  ram_dp_if.slave   bus
);

  localparam int C_DEPTH = 2 ** ADDR_WIDTH;

  generate
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("ram_dp_responder: RD_LATENCY must be 1 or 2");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] r_mem [C_DEPTH];
  logic [C_DEPTH-1:0]    r_wflag;
`ifdef RAM_PARITY_EN
  logic                  r_par [C_DEPTH];
`endif

  // Array itself carries no reset; the flags decide whether contents are valid.
  always_ff @(posedge clk) begin
    if (bus.we) begin
      r_mem[bus.wr_addr] <= bus.wr_din;
`ifdef RAM_PARITY_EN
      r_par[bus.wr_addr] <= (^bus.wr_din) ^ bus.wr_par_flip;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wflag <= '0;
    end else if (bus.we) begin
      r_wflag[bus.wr_addr] <= 1'b1;
    end
  end

  logic                  w_collide;
  logic [DATA_WIDTH-1:0] w_rsp_data;
  logic                  w_rsp_unwr;
  logic                  w_rsp_perr;

  assign w_collide = bus.we && (bus.wr_addr == bus.rd_addr);

  always_comb begin
    w_rsp_data = '0;
    w_rsp_unwr = 1'b0;
    w_rsp_perr = 1'b0;
    if (w_collide) begin
      w_rsp_data = bus.wr_din;
    end else if (!r_wflag[bus.rd_addr]) begin
      w_rsp_unwr = 1'b1;
    end else begin
      w_rsp_data = r_mem[bus.rd_addr];
`ifdef RAM_PARITY_EN
      w_rsp_perr = (^r_mem[bus.rd_addr]) != r_par[bus.rd_addr];
`endif
    end
  end

  // Feed into the output register: straight from the array (latency 1)
  // or through one extra pipeline stage (latency 2).
  logic                  w_fd_valid;
  logic [DATA_WIDTH-1:0] w_fd_data;
  logic                  w_fd_unwr;
  logic                  w_fd_perr;

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  r_s1_valid;
      logic [DATA_WIDTH-1:0] r_s1_data;
      logic                  r_s1_unwr;
      logic                  r_s1_perr;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s1_valid <= 1'b0;
          r_s1_data  <= '0;
          r_s1_unwr  <= 1'b0;
          r_s1_perr  <= 1'b0;
        end else begin
          r_s1_valid <= bus.re;
          if (bus.re) begin
            r_s1_data <= w_rsp_data;
            r_s1_unwr <= w_rsp_unwr;
            r_s1_perr <= w_rsp_perr;
          end
        end
      end

      assign w_fd_valid = r_s1_valid;
      assign w_fd_data  = r_s1_data;
      assign w_fd_unwr  = r_s1_unwr;
      assign w_fd_perr  = r_s1_perr;
    end else begin : g_lat1
      assign w_fd_valid = bus.re;
      assign w_fd_data  = w_rsp_data;
      assign w_fd_unwr  = w_rsp_unwr;
      assign w_fd_perr  = w_rsp_perr;
    end
  endgenerate

  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_dout;
  logic                  r_rd_unwr;
  logic                  r_rd_perr;

  // Data and unwritten flag hold between responses; the error bit pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_dout  <= '0;
      r_rd_unwr  <= 1'b0;
      r_rd_perr  <= 1'b0;
    end else begin
      r_rd_valid <= w_fd_valid;
      r_rd_perr  <= w_fd_valid && w_fd_perr;
      if (w_fd_valid) begin
        r_rd_dout <= w_fd_data;
        r_rd_unwr <= w_fd_unwr;
      end
    end
  end

  assign bus.rd_valid     = r_rd_valid;
  assign bus.rd_dout      = r_rd_dout;
  assign bus.rd_unwritten = r_rd_unwr;
`ifdef RAM_PARITY_EN
  assign bus.rd_parity_err = r_rd_perr;
`else
  logic w_perr_unused;
  assign w_perr_unused = r_rd_perr;
`endif

  a_no_x_ctrl : assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({bus.we, bus.re, bus.wr_addr, bus.rd_addr}))
    else $error("ram_dp_responder: X on control or address input");

endmodule

`default_nettype wire

// File: tb/tb_ram_dp_responder.sv
// Bench: one DUT at RD_LATENCY=1 and one at RD_LATENCY=2 share the stimulus;
// a per-read queue model is compared every cycle, plus literal spot checks.
`default_nettype none

module tb_ram_dp_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0, re = 1'b0, flip = 1'b0;
  logic [7:0] wr_addr = 8'h00, rd_addr = 8'h00, wr_din = 8'h00;

  int n_chk  = 0;
  int n_pass = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  ram_dp_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) b1 ();
  ram_dp_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) b2 ();

  assign b1.we = we;  assign b1.wr_addr = wr_addr;  assign b1.wr_din = wr_din;
  assign b1.re = re;  assign b1.rd_addr = rd_addr;
  assign b2.we = we;  assign b2.wr_addr = wr_addr;  assign b2.wr_din = wr_din;
  assign b2.re = re;  assign b2.rd_addr = rd_addr;

  logic p1, p2;
`ifdef RAM_PARITY_EN
  assign b1.wr_par_flip = flip;
  assign b2.wr_par_flip = flip;
  assign p1 = b1.rd_parity_err;
  assign p2 = b2.rd_parity_err;
`else
  assign p1 = 1'b0;
  assign p2 = 1'b0;
`endif

  ram_dp_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));
  ram_dp_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave));

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s lat%0d got=%0h want=%0h t=%0t", name, k, got, want, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int due; logic [7:0] d; logic u; logic p; } rsp_t;
  rsp_t q1[$];
  rsp_t q2[$];
  logic [7:0] m_mem [256];
  bit         m_flag[256];
  bit         m_par [256];
  logic [7:0] hold_d [2];
  logic       hold_u [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) m_flag[i] = 1'b0;
      q1.delete();
      q2.delete();
    end else begin
      rsp_t r;
      edge_n++;
      if (re) begin
        r.p = 1'b0;
        if (we && wr_addr == rd_addr) begin
          r.d = wr_din; r.u = 1'b0;
        end else if (!m_flag[rd_addr]) begin
          r.d = 8'h00; r.u = 1'b1;
        end else begin
          r.d = m_mem[rd_addr]; r.u = 1'b0;
`ifdef RAM_PARITY_EN
          r.p = (^m_mem[rd_addr]) != m_par[rd_addr];
`endif
        end
        r.due = edge_n;     q1.push_back(r);
        r.due = edge_n + 1; q2.push_back(r);
      end
      if (we) begin
        m_mem[wr_addr]  = wr_din;
        m_flag[wr_addr] = 1'b1;
        m_par[wr_addr]  = (^wr_din) ^ flip;
      end
    end
  end

  task automatic cmp_port(input int k, input logic v, input logic [7:0] d, input logic u, input logic p);
    rsp_t e;
    logic ev;
    ev = 1'b0;
    e.p = 1'b0;
    if (k == 0) begin
      if (q1.size() > 0 && q1[0].due == edge_n) begin ev = 1'b1; e = q1.pop_front(); end
    end else begin
      if (q2.size() > 0 && q2[0].due == edge_n) begin ev = 1'b1; e = q2.pop_front(); end
    end
    if (ev) begin hold_d[k] = e.d; hold_u[k] = e.u; end
    chk("rd_valid", k + 1, {31'd0, v}, {31'd0, ev});
    chk("rd_dout", k + 1, {24'd0, d}, {24'd0, hold_d[k]});
    chk("rd_unwritten", k + 1, {31'd0, u}, {31'd0, hold_u[k]});
    chk("rd_parity_err", k + 1, {31'd0, p}, {31'd0, ev & e.p});
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin hold_d[k] = 8'h00; hold_u[k] = 1'b0; end
      chk("rst_valid", 1, {31'd0, b1.rd_valid}, 32'd0);
      chk("rst_dout", 2, {24'd0, b2.rd_dout}, 32'd0);
    end else begin
      cmp_port(0, b1.rd_valid, b1.rd_dout, b1.rd_unwritten, p1);
      cmp_port(1, b2.rd_valid, b2.rd_dout, b2.rd_unwritten, p2);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; flip = 1'b0;
  endtask

  task automatic lit(input string name, input int k, input logic [7:0] d, input logic u, input logic v);
    if (k == 1) begin
      chk({name, "_dout"}, 1, {24'd0, b1.rd_dout}, {24'd0, d});
      chk({name, "_unwr"}, 1, {31'd0, b1.rd_unwritten}, {31'd0, u});
      chk({name, "_valid"}, 1, {31'd0, b1.rd_valid}, {31'd0, v});
    end else begin
      chk({name, "_dout"}, 2, {24'd0, b2.rd_dout}, {24'd0, d});
      chk({name, "_unwr"}, 2, {31'd0, b2.rd_unwritten}, {31'd0, u});
      chk({name, "_valid"}, 2, {31'd0, b2.rd_valid}, {31'd0, v});
    end
  endtask

  logic [7:0] vals [3];

  initial begin
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    repeat (3) tick();
    rst_n = 1'b1;

    // Unwritten read
    re = 1'b1; rd_addr = 8'h05;
    tick(); idle();
    lit("unwr", 1, 8'h00, 1'b1, 1'b1);
    tick();
    lit("unwr", 2, 8'h00, 1'b1, 1'b1);
    chk("unwr_pulse", 1, {31'd0, b1.rd_valid}, 32'd0);

    // Write then read
    we = 1'b1; wr_addr = 8'h10; wr_din = 8'hA5;
    tick(); idle();
    re = 1'b1; rd_addr = 8'h10;
    tick(); idle();
    lit("wr_rd", 1, 8'hA5, 1'b0, 1'b1);
    tick();
    lit("wr_rd", 2, 8'hA5, 1'b0, 1'b1);
    lit("wr_rd_hold", 1, 8'hA5, 1'b0, 1'b0);

    // Same-address collision: write-first
    we = 1'b1; wr_addr = 8'h20; wr_din = 8'h3C; re = 1'b1; rd_addr = 8'h20;
    tick(); idle();
    lit("collide", 1, 8'h3C, 1'b0, 1'b1);
    tick();
    lit("collide", 2, 8'h3C, 1'b0, 1'b1);

    // Different-address simultaneous write and read
    we = 1'b1; wr_addr = 8'h30; wr_din = 8'h55; re = 1'b1; rd_addr = 8'h10;
    tick(); idle();
    lit("indep", 1, 8'hA5, 1'b0, 1'b1);
    repeat (2) tick();

    // Back-to-back reads
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; wr_addr = 8'(i + 1); wr_din = vals[i];
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      re = 1'b1; rd_addr = 8'(i + 1);
      tick();
      lit("b2b", 1, vals[i], 1'b0, 1'b1);
      if (i > 0) lit("b2b", 2, vals[i-1], 1'b0, 1'b1);
    end
    idle();
    tick();
    lit("b2b", 2, 8'h33, 1'b0, 1'b1);
    repeat (3) tick();
    lit("b2b_hold", 2, 8'h33, 1'b0, 1'b0);

    // Reset while a read is in flight
    re = 1'b1; rd_addr = 8'h10;
    @(posedge clk);
    #2 rst_n = 1'b0;
    idle();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    lit("flush", 2, 8'h00, 1'b0, 1'b0);
    re = 1'b1; rd_addr = 8'h10;
    tick(); idle();
    lit("post_rst", 1, 8'h00, 1'b1, 1'b1);
    tick();
    lit("post_rst", 2, 8'h00, 1'b1, 1'b1);

`ifdef RAM_PARITY_EN
    we = 1'b1; wr_addr = 8'h07; wr_din = 8'h0F; flip = 1'b1;
    tick(); idle();
    re = 1'b1; rd_addr = 8'h07;
    tick(); idle();
    lit("par_bad", 1, 8'h0F, 1'b0, 1'b1);
    chk("par_bad_err", 1, {31'd0, p1}, 32'd1);
    tick();
    we = 1'b1; wr_addr = 8'h07; wr_din = 8'h0F; flip = 1'b0;
    tick(); idle();
    re = 1'b1; rd_addr = 8'h07;
    tick(); idle();
    chk("par_ok_err", 1, {31'd0, p1}, 32'd0);
    chk("par_ok_valid", 1, {31'd0, b1.rd_valid}, 32'd1);
    tick();
`endif

    repeat (4) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
